// File: rtl/vc_fifo_pkg.sv
// Shared definitions for the per-VC FIFOs in front of the VC arbiter/mux.
package vc_fifo_pkg;

  localparam int VC_DATA_WIDTH = 6;
  localparam int VC_NUM        = 2;
  localparam int AE_DEFAULT    = 1;

  // Accepted-operation encoding: {push_accepted, pop_accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int af_default(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

endpackage

// File: rtl/vc_fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, combinational read, no reset.
module vc_fifo_mem
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = VC_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vc_fifo.sv
// Per-virtual-channel FIFO with registered, zero-on-idle read port and count-based flags.
// Optional sticky overflow/underflow flag: define VC_FIFO_ERROR_EN.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = VC_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_AF,
  input  logic [ADDR_WIDTH:0]   umbral_AE,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_push_acc, w_pop_acc;
  fifo_op_e              w_op;

  assign full         = (r_count == CNT_FULL);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= umbral_AF);
  assign almost_empty = (r_count <= umbral_AE);

  // A full FIFO still takes a push when the same edge frees a slot; empty never falls through.
  assign w_pop_acc  = pop && !empty;
  assign w_push_acc = push && (!full || w_pop_acc);
  assign w_op       = fifo_op_e'({w_push_acc, w_pop_acc});

  vc_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        data_out  <= w_rdata;
        valid_out <= 1'b1;
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end
      case (w_op)
        OP_PUSH: r_count <= r_count + 1'b1;
        OP_POP:  r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef VC_FIFO_ERROR_EN
  logic r_error;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_error <= 1'b0;
    end else if ((push && full && !pop) || (pop && empty)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// Directed vector bench for vc_fifo (DEPTH 4, AF 3, AE 1) plus reset/wrap/threshold sequences.
module tb_vc_fifo;

`ifdef VC_FIFO_ERROR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk, reset_L, push, pop;
  logic [5:0] data_in, data_out;
  logic [2:0] umbral_AF, umbral_AE;
  logic       valid_out, full, empty, almost_full, almost_empty, error;

  int total = 0;
  int bad   = 0;

  vc_fifo dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .umbral_AF    (umbral_AF),
    .umbral_AE    (umbral_AE),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic [5:0] din;
    logic [5:0] dout;
    logic       vld;
    logic [3:0] flg;  // {full, empty, almost_full, almost_empty}
    logic       err;  // expected error when the sticky flag is built
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(input logic pu, input logic po, input logic [5:0] di,
                              input logic [5:0] dout, input logic vl,
                              input logic [3:0] flg, input logic er);
    vec_t v;
    v.push = pu; v.pop = po; v.din = di; v.dout = dout; v.vld = vl; v.flg = flg; v.err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] dout, input logic vld,
                         input logic [3:0] flg, input logic er);
    chk({tag, " data_out"}, 8'(data_out), 8'(dout));
    chk({tag, " valid_out"}, 8'(valid_out), 8'(vld));
    chk({tag, " flags"}, 8'({full, empty, almost_full, almost_empty}), 8'(flg));
    chk({tag, " error"}, 8'(error), 8'(er));
  endtask

  task automatic step(input logic pu, input logic po, input logic [5:0] di);
    @(negedge clk);
    push = pu; pop = po; data_in = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 6'h01, 6'h00, 0, 4'b0001, 0);
    tbl[1]  = mk(1, 0, 6'h02, 6'h00, 0, 4'b0000, 0);
    tbl[2]  = mk(1, 0, 6'h03, 6'h00, 0, 4'b0010, 0);
    tbl[3]  = mk(1, 0, 6'h04, 6'h00, 0, 4'b1010, 0);
    tbl[4]  = mk(0, 1, 6'h00, 6'h01, 1, 4'b0010, 0);
    tbl[5]  = mk(0, 1, 6'h00, 6'h02, 1, 4'b0000, 0);
    tbl[6]  = mk(0, 1, 6'h00, 6'h03, 1, 4'b0001, 0);
    tbl[7]  = mk(0, 1, 6'h00, 6'h04, 1, 4'b0101, 0);
    tbl[8]  = mk(0, 0, 6'h00, 6'h00, 0, 4'b0101, 0);
    tbl[9]  = mk(1, 0, 6'h0A, 6'h00, 0, 4'b0001, 0);
    tbl[10] = mk(1, 0, 6'h0B, 6'h00, 0, 4'b0000, 0);
    tbl[11] = mk(1, 0, 6'h0C, 6'h00, 0, 4'b0010, 0);
    tbl[12] = mk(1, 0, 6'h0D, 6'h00, 0, 4'b1010, 0);
    tbl[13] = mk(1, 1, 6'h3F, 6'h0A, 1, 4'b1010, 0);  // full + push + pop
    tbl[14] = mk(0, 1, 6'h00, 6'h0B, 1, 4'b0010, 0);
    tbl[15] = mk(0, 1, 6'h00, 6'h0C, 1, 4'b0000, 0);
    tbl[16] = mk(0, 1, 6'h00, 6'h0D, 1, 4'b0001, 0);
    tbl[17] = mk(0, 1, 6'h00, 6'h3F, 1, 4'b0101, 0);
    tbl[18] = mk(1, 1, 6'h15, 6'h00, 0, 4'b0001, 0);  // empty + push + pop: no fall-through
    tbl[19] = mk(0, 1, 6'h00, 6'h15, 1, 4'b0101, 0);
    tbl[20] = mk(0, 1, 6'h00, 6'h00, 0, 4'b0101, 1);  // underflow
    tbl[21] = mk(1, 0, 6'h21, 6'h00, 0, 4'b0001, 1);
    tbl[22] = mk(1, 0, 6'h22, 6'h00, 0, 4'b0000, 1);
    tbl[23] = mk(1, 0, 6'h23, 6'h00, 0, 4'b0010, 1);
    tbl[24] = mk(1, 0, 6'h24, 6'h00, 0, 4'b1010, 1);
    tbl[25] = mk(1, 0, 6'h2F, 6'h00, 0, 4'b1010, 1);  // overflow: 0x2F dropped
    tbl[26] = mk(0, 1, 6'h00, 6'h21, 1, 4'b0010, 1);
    tbl[27] = mk(0, 1, 6'h00, 6'h22, 1, 4'b0000, 1);
    tbl[28] = mk(0, 1, 6'h00, 6'h23, 1, 4'b0001, 1);
    tbl[29] = mk(0, 1, 6'h00, 6'h24, 1, 4'b0101, 1);
    tbl[30] = mk(0, 0, 6'h00, 6'h00, 0, 4'b0101, 1);

    reset_L = 1'b0; push = 1'b0; pop = 1'b0; data_in = 6'h00;
    umbral_AF = 3'd3; umbral_AE = 3'd1;
    #12;
    chk_all("reset", 6'h00, 1'b0, 4'b0101, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;

    for (int i = 0; i < 31; i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].din);
      chk_all($sformatf("v%0d", i), tbl[i].dout, tbl[i].vld, tbl[i].flg, tbl[i].err & ERR_EN);
    end

    // Asynchronous reset between edges with two words stored and valid_out high
    step(1, 0, 6'h31);
    step(1, 0, 6'h32);
    step(1, 0, 6'h33);
    step(0, 1, 6'h00);
    chk_all("pre_rst", 6'h31, 1'b1, 4'b0000, ERR_EN);
    #2;
    reset_L = 1'b0;
    #1;
    chk_all("mid_rst", 6'h00, 1'b0, 4'b0101, 1'b0);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    reset_L = 1'b1;

    // Six words streamed through with overlapping push/pop wrap both pointers
    for (int i = 0; i <= 6; i++) begin
      step(i < 6, i > 0, 6'h28 + 6'(i));
      chk_all($sformatf("wrap%0d", i), (i > 0) ? 6'h28 + 6'(i - 1) : 6'h00,
              i > 0, (i < 6) ? 4'b0001 : 4'b0101, 1'b0);
    end

    // Thresholds above DEPTH: almost_full never, almost_empty always
    step(0, 0, 6'h00);
    umbral_AF = 3'd5; umbral_AE = 3'd5;
    #1;
    chk_all("thr_empty", 6'h00, 1'b0, 4'b0101, 1'b0);
    for (int i = 0; i < 4; i++) step(1, 0, 6'h01);
    chk_all("thr_full", 6'h00, 1'b0, 4'b1001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
